rpn_evaluator: RTL
==================

// Module: rpn_evaluator
// PURPOSE
//  Reverse-Polish integer evaluator that sits directly upstream of the LIFO stack stage and drives its
//  push/pop/data_in port, reading pops back from its data_out.
//  Consumes a valid/ready token stream (operands and operators) and emits evaluated results.
//  Keeps its own occupancy count and never relies on the stack's empty/full flags.
// PARAMETERS
//  DATA_WIDTH   16  operand/result width; must equal the stack stage data_width
//  STACK_DEPTH  3   entries in the attached stack; must equal the stack stage data_count
// PORTS
//  clock         in   1           single clock, all state updates on posedge
//  reset_n       in   1           asynchronous, active-low reset
//  tok_valid     in   1           token present
//  tok_ready     out  1           block accepts token this cycle
//  tok_is_op     in   1           1: tok_data[2:0] is opcode; 0: tok_data is operand
//  tok_data      in   DATA_WIDTH  operand value or opcode
//  stk_push      out  1           push strobe to stack
//  stk_pop       out  1           pop strobe to stack
//  stk_data_in   out  DATA_WIDTH  value pushed
//  stk_data_out  in   DATA_WIDTH  stack output; valid one cycle after stk_pop
//  result_valid  out  1           one-cycle pulse, result holds popped top
//  result        out  DATA_WIDTH  last result, held until next pulse
//  depth         out  $clog2(STACK_DEPTH+1)  internal occupancy count
//  error         out  1           sticky; set on overflow/underflow/illegal opcode
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; depth=0; error=0; result=0; result_valid=0;
//   stk_push=stk_pop=0; stk_data_in=0; tok_ready=0 while in reset, 1 in IDLE afterwards.
//  All outputs registered. stk_push and stk_pop are never high in the same cycle.
//  tok_ready=1 only in IDLE and ERR; handshake = tok_valid & tok_ready at posedge.
//  Opcodes (A = deeper entry, B = top): 000 ADD A+B; 001 SUB A-B; 010 MUL low DATA_WIDTH bits of A*B;
//   011 AND; 100 OR; 101 XOR; 111 RES (pop top to result); 110 illegal. All arithmetic mod 2^DATA_WIDTH.
//  FSM:
//   IDLE   -> operand: if depth==STACK_DEPTH -> ERR, else latch value -> PUSH
//             binary op: depth<2 -> ERR, else -> POP_B; RES: depth==0 -> ERR, else -> POP_R; 110 -> ERR
//   PUSH   stk_push=1, stk_data_in=value, depth+1 -> IDLE (operand latency: 2 cycles to next ready)
//   POP_B  stk_pop=1 -> CAP_B; CAP_B captures stk_data_out into B -> POP_A
//   POP_A  stk_pop=1 -> CAP_A; CAP_A captures A -> PUSH_R
//   PUSH_R stk_push=1, stk_data_in=f(A,B), depth-1 net -> IDLE (binary op: 6 cycles handshake to ready)
//   POP_R  stk_pop=1 -> CAP_R; CAP_R captures stk_data_out into result, depth-1, result_valid=1
//          next cycle -> IDLE
//   ERR    error=1; tok_ready=1, tokens discarded, no stack strobes; exit only by reset
//  Faulting token is consumed with no stack access; depth is unchanged on error.
//  Reset mid-operation aborts any sequence immediately; the stack stage has no reset,
//   so system reset must also re-initialise the stack; stale stack contents are ignored.
// TESTING
//  push 3, push 4, ADD, RES -> stk_push x3, stk_pop x3, result=7 pulse, depth 0, error=0
//  push 10, push 3, SUB, RES -> result=7; push 3, push 10, SUB, RES -> result=16'hFFF9
//  push 16'h0100 x2, MUL, RES -> result=16'h0000 (truncation), error=0
//  push 1,2,3 then push 4 -> error=1, depth stays 3, no 4th stk_push, later tokens absorbed
//  ADD with depth 1 -> error=1, no stk_pop; opcode 110 at depth 0 -> error=1
//  reset_n low during CAP_A -> all outputs zero next sample, depth 0; push 5, RES -> result=5

Source files
------------

// File: rtl/rpn_evaluator_if.sv
// Token, stack-port and result bundle of the RPN evaluator.
// slave is the evaluator side; master is the token source plus attached stack.
interface rpn_evaluator_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH_WIDTH = 2
);
   logic                   tok_valid;
   logic                   tok_ready;
   logic                   tok_is_op;
   logic [DATA_WIDTH-1:0]  tok_data;
   logic                   stk_push;
   logic                   stk_pop;
   logic [DATA_WIDTH-1:0]  stk_data_in;
   logic [DATA_WIDTH-1:0]  stk_data_out;
   logic                   result_valid;
   logic [DATA_WIDTH-1:0]  result;
   logic [DEPTH_WIDTH-1:0] depth;
   logic                   error;

   modport master (
      output tok_valid,
      output tok_is_op,
      output tok_data,
      output stk_data_out,
      input  tok_ready,
      input  stk_push,
      input  stk_pop,
      input  stk_data_in,
      input  result_valid,
      input  result,
      input  depth,
      input  error
   );

   modport slave (
      input  tok_valid,
      input  tok_is_op,
      input  tok_data,
      input  stk_data_out,
      output tok_ready,
      output stk_push,
      output stk_pop,
      output stk_data_in,
      output result_valid,
      output result,
      output depth,
      output error
   );
endinterface

// File: rtl/rpn_evaluator.sv
// Reverse-Polish evaluator driving an external LIFO stage.
// Tracks occupancy itself; all outputs come straight from flops.
module rpn_evaluator #(
   parameter int DATA_WIDTH  = 16,
   parameter int STACK_DEPTH = 3
) (
   input  logic           clock,
   input  logic           reset_n,
   rpn_evaluator_if.slave bus
);
   localparam int DW = $clog2(STACK_DEPTH + 1);
   localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);
   localparam logic [DW-1:0] TWO  = DW'(2);
   localparam logic [DW-1:0] ONE  = DW'(1);
   localparam logic [2:0] OP_BAD = 3'b110;
   localparam logic [2:0] OP_RES = 3'b111;

   typedef enum logic [3:0] {
      IDLE, PUSH, POP_B, CAP_B, POP_A,
      CAP_A, PUSH_R, POP_R, CAP_R, ERR
   } state_t;

   state_t state_q, state_d;

   logic [DW-1:0]         depth_q, depth_d;
   logic [2:0]            op_q, op_d;
   logic [DATA_WIDTH-1:0] b_q, b_d;
   logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  rvalid_q, rvalid_d;
   logic                  error_q, error_d;
   logic                  ready_q, ready_d;
   logic                  push_q, push_d;
   logic                  pop_q, pop_d;

   logic       accept;
   logic [2:0] opc;
   logic       is_push, is_res, is_bad;

   function automatic logic [DATA_WIDTH-1:0] alu(
      input logic [2:0]            op,
      input logic [DATA_WIDTH-1:0] a,
      input logic [DATA_WIDTH-1:0] b
   );
      logic [DATA_WIDTH-1:0] r;
      unique case (op)
         3'b001:  r = a - b;
         3'b010:  r = a * b;
         3'b011:  r = a & b;
         3'b100:  r = a | b;
         3'b101:  r = a ^ b;
         default: r = a + b;
      endcase
      return r;
   endfunction

   assign accept  = bus.tok_valid & ready_q;
   assign opc     = bus.tok_data[2:0];
   assign is_push = !bus.tok_is_op;
   assign is_res  = bus.tok_is_op && (opc == OP_RES);
   assign is_bad  = bus.tok_is_op && (opc == OP_BAD);

   always_comb begin
      state_d   = state_q;
      depth_d   = depth_q;
      op_d      = op_q;
      b_d       = b_q;
      data_in_d = data_in_q;
      result_d  = result_q;
      rvalid_d  = 1'b0;
      error_d   = error_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               unique case (1'b1)
                  is_push: begin
                     if (depth_q == FULL) begin
                        state_d = ERR;
                     end else begin
                        data_in_d = bus.tok_data;
                        state_d   = PUSH;
                     end
                  end
                  is_res: begin
                     if (depth_q == '0) state_d = ERR;
                     else               state_d = POP_R;
                  end
                  is_bad: state_d = ERR;
                  default: begin
                     if (depth_q < TWO) begin
                        state_d = ERR;
                     end else begin
                        op_d    = opc;
                        state_d = POP_B;
                     end
                  end
               endcase
            end
         end
         PUSH: begin
            depth_d = depth_q + ONE;
            state_d = IDLE;
         end
         POP_B: state_d = CAP_B;
         CAP_B: begin
            b_d     = bus.stk_data_out;
            state_d = POP_A;
         end
         POP_A: state_d = CAP_A;
         // A is consumed straight off the stack so the result is ready for PUSH_R
         CAP_A: begin
            data_in_d = alu(op_q, bus.stk_data_out, b_q);
            state_d   = PUSH_R;
         end
         PUSH_R: begin
            depth_d = depth_q - ONE;
            state_d = IDLE;
         end
         POP_R: state_d = CAP_R;
         CAP_R: begin
            result_d = bus.stk_data_out;
            rvalid_d = 1'b1;
            depth_d  = depth_q - ONE;
            state_d  = IDLE;
         end
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
      if (state_d == ERR) error_d = 1'b1;
      ready_d = (state_d == IDLE) || (state_d == ERR);
      push_d  = (state_d == PUSH) || (state_d == PUSH_R);
      pop_d   = (state_d == POP_B) || (state_d == POP_A)
             || (state_d == POP_R);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         depth_q   <= '0;
         op_q      <= '0;
         b_q       <= '0;
         data_in_q <= '0;
         result_q  <= '0;
         rvalid_q  <= 1'b0;
         error_q   <= 1'b0;
         ready_q   <= 1'b0;
         push_q    <= 1'b0;
         pop_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         depth_q   <= depth_d;
         op_q      <= op_d;
         b_q       <= b_d;
         data_in_q <= data_in_d;
         result_q  <= result_d;
         rvalid_q  <= rvalid_d;
         error_q   <= error_d;
         ready_q   <= ready_d;
         push_q    <= push_d;
         pop_q     <= pop_d;
      end
   end

   assign bus.tok_ready    = ready_q;
   assign bus.stk_push     = push_q;
   assign bus.stk_pop      = pop_q;
   assign bus.stk_data_in  = data_in_q;
   assign bus.result_valid = rvalid_q;
   assign bus.result       = result_q;
   assign bus.depth        = depth_q;
   assign bus.error        = error_q;
endmodule
